// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state enum, the digit width and a digit-count helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_W = 4;

    // ceil(width * log10(2)) in fixed point; decimal digits needed for 2^width-1
    function automatic int min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One double-dabble BCD digit: doubles its value and shifts in a carry bit.
// cout flags that the doubled value wraps past 9 into the next digit.
module bcd_digit_cell
    import bin2bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             in,
    output logic [BCD_W-1:0] digit,
    output logic             cout
);

    logic [BCD_W-1:0] sub5;
    logic [BCD_W-1:0] digit_nxt;

    assign cout = (digit >= 4'd5);
    assign sub5 = digit - 4'd5;

    always_comb begin
        digit_nxt = digit;
        if (cout)
            digit_nxt = {sub5[2:0], in};
        else
            digit_nxt = {digit[2:0], in};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            digit <= '0;
        else if (clr)
            digit <= '0;
        else if (en)
            digit <= digit_nxt;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter with start/done handshake.
// Define BIN2BCD_SIGN_EN to treat bin as two's complement and report sign.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        bin,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    ovf,
    output logic                    sign
);

    localparam int CW = $clog2(WIDTH);

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  sreg;
    logic [WIDTH-1:0]  operand;
    logic [CW-1:0]     cnt;
    logic [DIGITS:0]   carry;
    logic              accept;
    logic              shift;
    logic              last;

    assign ready  = (state != SHIFT);
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign accept = start && ready;
    assign shift  = busy;
    assign last   = (cnt == CW'(WIDTH - 1));

`ifdef BIN2BCD_SIGN_EN
    // -2^(WIDTH-1) negates to itself, which reads correctly as unsigned
    assign operand = bin[WIDTH-1] ? (~bin) + {{(WIDTH-1){1'b0}}, 1'b1} : bin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sign <= 1'b0;
        else if (accept)
            sign <= bin[WIDTH-1];
    end
`else
    assign operand = bin;
    assign sign    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= operand;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= sreg << 1;
            cnt  <= cnt + 1'b1;
        end
    end

    assign carry[0] = sreg[WIDTH-1];

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .clr   (accept),
            .en    (shift),
            .in    (carry[k]),
            .digit (bcd[BCD_W*k +: BCD_W]),
            .cout  (carry[k+1])
        );
    end

    // Sticky: any carry past the top digit means the value was truncated
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf <= 1'b0;
        else if (accept)
            ovf <= 1'b0;
        else if (shift && carry[DIGITS])
            ovf <= 1'b1;
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 5-digit and 4-digit instances, WIDTH=16.
// Expected values follow the build's BIN2BCD_SIGN_EN setting.
module tb_bin2bcd_seq;

    typedef struct {
        int          which;
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
        logic        sign;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start5 = 1'b0;
    logic        start4 = 1'b0;
    logic [15:0] bin = '0;

    logic        ready5, busy5, done5, ovf5, sign5;
    logic [19:0] bcd5;
    logic        ready4, busy4, done4, ovf4, sign4;
    logic [15:0] bcd4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start5),
        .bin   (bin),
        .ready (ready5),
        .busy  (busy5),
        .done  (done5),
        .bcd   (bcd5),
        .ovf   (ovf5),
        .sign  (sign5)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .start (start4),
        .bin   (bin),
        .ready (ready4),
        .busy  (busy4),
        .done  (done4),
        .bcd   (bcd4),
        .ovf   (ovf4),
        .sign  (sign4)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic get_done(input int which);
        return (which == 4) ? done4 : done5;
    endfunction

    task automatic run_conv(input int which, input logic [15:0] v,
                            input logic [19:0] eb, input logic eo,
                            input logic es, input string nm);
        int n;
        @(negedge clk);
        bin = v;
        if (which == 4) start4 = 1'b1;
        else start5 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        start5 = 1'b0;
        n = 1;
        while (!get_done(which) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, 17);
        if (which == 4) begin
            chk({nm, " bcd"}, {16'h0, bcd4}, {12'h0, eb});
            chk({nm, " ovf"}, ovf4, eo);
            chk({nm, " sign"}, sign4, es);
        end else begin
            chk({nm, " bcd"}, bcd5, eb);
            chk({nm, " ovf"}, ovf5, eo);
            chk({nm, " sign"}, sign5, es);
        end
        @(negedge clk);
        chk({nm, " done pulse"}, get_done(which), 1'b0);
    endtask

    initial begin
        vec_t vecs[$];
        vecs.push_back('{5, 16'd0,     20'h00000, 1'b0, 1'b0});
        vecs.push_back('{5, 16'd1234,  20'h01234, 1'b0, 1'b0});
        vecs.push_back('{5, 16'd9,     20'h00009, 1'b0, 1'b0});
        vecs.push_back('{5, 16'h7FFF,  20'h32767, 1'b0, 1'b0});
        vecs.push_back('{4, 16'd10000, 20'h00000, 1'b1, 1'b0});
        vecs.push_back('{4, 16'd9999,  20'h09999, 1'b0, 1'b0});
        vecs.push_back('{4, 16'd12345, 20'h02345, 1'b1, 1'b0});
`ifdef BIN2BCD_SIGN_EN
        vecs.push_back('{5, 16'hFFFF,  20'h00001, 1'b0, 1'b1});
        vecs.push_back('{5, 16'h8000,  20'h32768, 1'b0, 1'b1});
        vecs.push_back('{5, 16'd40961, 20'h24575, 1'b0, 1'b1});
        vecs.push_back('{4, 16'h8000,  20'h02768, 1'b1, 1'b1});
`else
        vecs.push_back('{5, 16'd65535, 20'h65535, 1'b0, 1'b0});
        vecs.push_back('{5, 16'd40961, 20'h40961, 1'b0, 1'b0});
        vecs.push_back('{5, 16'h8000,  20'h32768, 1'b0, 1'b0});
        vecs.push_back('{4, 16'd65535, 20'h05535, 1'b1, 1'b0});
`endif

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst ready", ready5, 1'b1);
        chk("rst busy", busy5, 1'b0);
        chk("rst done", done5, 1'b0);
        chk("rst bcd", bcd5, 20'h0);
        chk("rst ovf", ovf5, 1'b0);
        chk("rst sign", sign5, 1'b0);
        chk("rst ready4", ready4, 1'b1);

        foreach (vecs[i])
            run_conv(vecs[i].which, vecs[i].bin, vecs[i].bcd,
                     vecs[i].ovf, vecs[i].sign, $sformatf("vec%0d", i));

        // back-to-back: start held high, bin changed while busy
        @(negedge clk);
        bin = 16'd1234;
        start5 = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (c == 1) bin = 16'd4321;
            if (c == 5) begin
                chk("b2b busy", busy5, 1'b1);
                chk("b2b ready", ready5, 1'b0);
            end
            chk($sformatf("b2b done c%0d", c), done5, (c == 17 || c == 34));
            if (c == 17) chk("b2b bcd1", bcd5, 20'h01234);
            if (c == 34) begin
                chk("b2b bcd2", bcd5, 20'h04321);
                start5 = 1'b0;
            end
        end

        // stray start pulse during busy must be ignored
        @(negedge clk);
        bin = 16'd777;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (c == 5) begin
                bin = 16'd555;
                start5 = 1'b1;
            end
            if (c == 6) start5 = 1'b0;
            chk($sformatf("ign done c%0d", c), done5, (c == 17));
            if (c == 17) chk("ign bcd", bcd5, 20'h00777);
            @(negedge clk);
        end

        // reset mid-conversion
        run_conv(4, 16'd10000, 20'h00000, 1'b1, 1'b0, "pre_rst");
        @(negedge clk);
        bin = 16'hFFFF;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid busy", busy5, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst ready", ready5, 1'b1);
        chk("arst busy", busy5, 1'b0);
        chk("arst done", done5, 1'b0);
        chk("arst bcd", bcd5, 20'h0);
        chk("arst ovf4", ovf4, 1'b0);
        chk("arst sign", sign5, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done5) seen++;
            end
            chk("no partial done", seen, 0);
        end
`ifdef BIN2BCD_SIGN_EN
        run_conv(5, 16'd40961, 20'h24575, 1'b0, 1'b1, "post_rst");
`else
        run_conv(5, 16'd40961, 20'h40961, 1'b0, 1'b0, "post_rst");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised sequential binary-to-BCD converter. It uses shift-and-correct (double-dabble): one input bit per clock enters a chain of DIGITS BCD digit cells, each of which doubles its value and carries into the next. It replaces single-digit shifter instances in the display/readout path with one block that has a start/done handshake. An optional overflow flag covers conversions whose value exceeds DIGITS decimal digits.

## Interface
- WIDTH, 16, binary input width (≥2)
- DIGITS, 5, number of BCD output digits (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- start  input  1  request conversion of bin; accepted only when ready=1
- bin  input  WIDTH  binary operand, sampled on the accepting edge only
- ready  output  1  block can accept start (IDLE or DONE state)
- busy  output  1  conversion in progress (SHIFT state)
- done  output  1  one-cycle pulse, result valid
- bcd  output  4*DIGITS  result; digit k is bcd[4k+3:4k], digit 0 is least significant
- ovf  output  1  result exceeded 10^DIGITS−1; bcd then holds the value mod 10^DIGITS
- sign  output  1  input was negative (only meaningful with BIN2BCD_SIGN_EN)

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on start.
  - SHIFT → DONE when the bit counter reaches WIDTH−1.
  - DONE → SHIFT on start, else DONE → IDLE.
- Accept edge (start && ready):
  - shift register ← operand
  - all digits ← 0
  - bit counter ← 0
  - ovf ← 0
  - sign latched
- SHIFT cycle:
  - shift register shifts left; its MSB enters digit 0.
  - Each digit d: if d≥5, next = {(d−5)[2:0], in}, else next = {d[2:0], in}; cout = (d≥5).
  - in for digit k>0 is the cout of digit k−1, evaluated on the same edge.
  - Carry out of digit DIGITS−1 ORs into ovf (sticky until the next accept).
- Digits stay in 0..9 at all times. Codes 10–15 never occur; if forced, the cell treats them as d≥5 arithmetic.
- bcd, ovf and sign hold their last result through IDLE until the next accept.
- start while busy is ignored (no queueing).
- bin changes outside the accept edge have no effect.

## Timing
- Reset values:
  - ready=1, busy=0, done=0, ovf=0, sign=0
  - bcd=0, FSM=IDLE, counter=0
- Start accepted at edge 0. busy is high for cycles 1..WIDTH. done is high for exactly cycle WIDTH+1, with bcd/ovf/sign valid from that cycle.
- Latency is WIDTH+1 clocks for every operand, independent of value.
- Back-to-back operation: start during the DONE cycle is accepted, giving throughput of one result per WIDTH+1 clocks.
- Reset mid-conversion aborts immediately to the reset values. A partial result is never presented.
- busy, ready and done are registered-state decodes; no combinational path from start to any output.

## Configuration
- BIN2BCD_SIGN_EN defined:
  - bin is treated as two's complement.
  - sign ← bin[WIDTH−1] at accept, and the shift register loads the magnitude (−bin when negative).
  - −2^(WIDTH−1) converts to magnitude 2^(WIDTH−1), which fits in WIDTH unsigned bits.
- BIN2BCD_SIGN_EN undefined:
  - bin is unsigned.
  - sign is tied to 0.
  - No negation logic is instantiated.
- Latency is identical in both builds.

## Structure
- bin2bcd_pkg holds:
  - state enum (IDLE, SHIFT, DONE)
  - BCD_W = 4 constant
  - function min_digits(width) = ceil(width·log10 2), for assertion that DIGITS is sufficient; ovf is still required when it is not
- Sub-module bcd_digit_cell, instantiated DIGITS times in a generate loop:
  - inputs: clk, reset, clr, en, in
  - outputs: digit[3:0] registered, cout combinational (digit≥5)

## Test plan
- WIDTH=16, DIGITS=5, bin=0 → done at cycle 17, bcd=0x00000, ovf=0.
- bin=65535 → bcd=0x65535, ovf=0. bin=40961 → bcd=0x40961.
- WIDTH=16, DIGITS=4, bin=10000 → bcd=0x0000, ovf=1. Next conversion bin=9999 → bcd=0x9999, ovf=0.
- Back-to-back: start held high with bin=1234 then 4321 → done pulses at cycles 17 and 34, results 0x01234 and 0x04321. start during busy is ignored.
- reset asserted at cycle 8 of a conversion → all outputs at reset values next cycle, FSM in IDLE; a fresh start converts correctly.
- BIN2BCD_SIGN_EN defined, WIDTH=16:
  - bin=0xFFFF → sign=1, bcd=0x00001
  - bin=0x8000 → sign=1, bcd=0x32768
  - bin=0x7FFF → sign=0, bcd=0x32767
